// File: rtl/demux8_rr_scheduler_pkg.sv
// Shared types, sizes and helpers for the 8-way demux scheduler.
package demux_sched_pkg;

    localparam int unsigned NUM_DST = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        ROUTE  = 2'd2
    } state_t;

    // One-hot decode of a destination index.
    function automatic logic [NUM_DST-1:0] onehot8(input logic [SEL_W-1:0] sel);
        return NUM_DST'(1) << sel;
    endfunction

endpackage

// File: rtl/demux8_rr_scheduler_if.sv
// Upstream handshake plus demux-side select/data/strobe bundle.
interface demux8_rr_scheduler_if;
    import demux_sched_pkg::*;

    logic               in_valid;
    logic               in_data;
    logic               in_ready;
    logic [NUM_DST-1:0] dst_ready;
    logic [SEL_W-1:0]   S;
    logic               I;
    logic [NUM_DST-1:0] O_strb;

    // Environment side: produces items and destination readiness.
    modport master (
        output in_valid, in_data, dst_ready,
        input  in_ready, S, I, O_strb
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_data, dst_ready,
        output in_ready, S, I, O_strb
    );

endinterface

// File: rtl/demux8_rr_scheduler_rr_pick8.sv
// Rotating-priority finder: first set req bit at or after ptr, cyclically.
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [NUM_DST-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx     = '0;
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        for (int k = int'(NUM_DST) - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8_rr_scheduler.sv
// Round-robin burst scheduler driving a 1-to-8 bit demux.
module demux8_rr_scheduler
    import demux_sched_pkg::*;
#(
    parameter int unsigned BURST = 4,
    parameter int unsigned CW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    demux8_rr_scheduler_if.slave  bus,
    output logic                  busy,
    output logic                  round_done
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel;
    logic [CW-1:0]    cnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             in_ready_c;
    logic             xfer_c;
    logic             last_beat_c;
    logic             wrap_c;
    logic [SEL_W-1:0] next_ptr_c;

    rr_pick8 u_pick (
        .req     (bus.dst_ready),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Upstream may only hand over an item while routing to a ready destination.
    assign in_ready_c  = (state == ROUTE) && bus.dst_ready[sel] && en;
    assign bus.in_ready = in_ready_c;

    assign xfer_c      = bus.in_valid && in_ready_c;
    assign last_beat_c = (cnt == CW'(BURST - 1));
    assign next_ptr_c  = sel + SEL_W'(1);
    // A turn ending on the last destination moves ptr 7->0 unless ptr was already 0.
    assign wrap_c      = (sel == SEL_W'(NUM_DST - 1)) && (ptr != '0);

    // Scheduler FSM with registered demux outputs and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            sel        <= '0;
            cnt        <= '0;
            bus.S      <= '0;
            bus.I      <= 1'b0;
            bus.O_strb <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
        end else begin
            bus.O_strb <= '0;
            round_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= SEARCH;
                        busy  <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gnt_vld) begin
                        sel   <= gnt_idx;
                        cnt   <= '0;
                        state <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (xfer_c) begin
                        bus.S      <= sel;
                        bus.I      <= bus.in_data;
                        bus.O_strb <= onehot8(sel);
                        cnt        <= cnt + CW'(1);
                        if (last_beat_c) begin
                            ptr        <= next_ptr_c;
                            round_done <= wrap_c;
                            state      <= SEARCH;
                        end
                    end else if (!bus.dst_ready[sel]) begin
                        // Destination went away: the partial burst still uses the turn.
                        ptr        <= next_ptr_c;
                        round_done <= wrap_c;
                        state      <= SEARCH;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux8_rr_scheduler.sv
// Directed scoreboard bench for demux8_rr_scheduler (BURST=4 and BURST=1 instances).
module tb_demux8_rr_scheduler;
    import demux_sched_pkg::*;

    typedef struct packed {
        logic [2:0] s;
        logic       d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1;
    logic       rst1 = 1'b1;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic [7:0] dst_ready = 8'h00;
    logic       busy0, rd0, busy1, rd1;

    logic pat [0:63];
    int   cyc, sent, pk, act1;
    int   tot0, tot1, rdc0, rdc1, first0, last0;
    int   scnt0 [0:7];
    logic rd_at_last;
    int   dropped;

    demux8_rr_scheduler_if bus0 ();
    demux8_rr_scheduler_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.dst_ready = dst_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.dst_ready = dst_ready;

    demux8_rr_scheduler #(.BURST(4), .CW(4)) u_dut0 (
        .clk        (clk),
        .rst        (rst0),
        .en         (en),
        .bus        (bus0),
        .busy       (busy0),
        .round_done (rd0)
    );

    demux8_rr_scheduler #(.BURST(1), .CW(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst1),
        .en         (en),
        .bus        (bus1),
        .busy       (busy1),
        .round_done (rd1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back('{s: 3'(s), d: pat[pk]});
            pk++;
        end
    endtask

    // Compare any strobe against the head of the matching scoreboard queue.
    task automatic monitor();
        exp_t e;
        if (bus0.O_strb !== 8'h00) begin
            tot0++;
            scnt0[bus0.S]++;
            if (first0 < 0) first0 = cyc;
            last0 = cyc;
            if (q0.size() == 0) begin
                chk("dut0_unexpected_strobe", 32'(bus0.O_strb), 32'h0);
            end else begin
                e = q0.pop_front();
                chk("dut0_S", 32'(bus0.S), 32'(e.s));
                chk("dut0_I", 32'(bus0.I), 32'(e.d));
                chk("dut0_strb", 32'(bus0.O_strb), 32'(8'(1) << e.s));
                if (q0.size() == 0) rd_at_last = rd0;
            end
        end
        if (rd0 === 1'b1) rdc0++;
        if (bus1.O_strb !== 8'h00) begin
            tot1++;
            if (q1.size() == 0) begin
                chk("dut1_unexpected_strobe", 32'(bus1.O_strb), 32'h0);
            end else begin
                e = q1.pop_front();
                chk("dut1_S", 32'(bus1.S), 32'(e.s));
                chk("dut1_I", 32'(bus1.I), 32'(e.d));
                chk("dut1_strb", 32'(bus1.O_strb), 32'(8'(1) << e.s));
            end
        end
        if (rd1 === 1'b1) rdc1++;
    endtask

    // One clock: note the handshake, clock, sample on the falling edge, advance data.
    task automatic step();
        logic hs;
        #1;
        hs = in_valid && ((act1 != 0) ? bus1.in_ready : bus0.in_ready);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        monitor();
        if (hs) sent++;
        in_data = pat[sent & 63];
    endtask

    task automatic begin_scn();
        cyc = 0; sent = 0; pk = 0;
        tot0 = 0; tot1 = 0; rdc0 = 0; rdc1 = 0;
        first0 = -1; last0 = -1; rd_at_last = 1'b0;
        for (int i = 0; i < 8; i++) scnt0[i] = 0;
        in_data = pat[0];
    endtask

    task automatic reset0();
        rst0 = 1'b1; en = 1'b0; in_valid = 1'b0; dst_ready = 8'h00;
        step();
        rst0 = 1'b0;
    endtask

    initial begin
        logic [7:0] p6;
        act1 = 0;
        for (int i = 0; i < 64; i++) pat[i] = 1'($urandom);
        begin_scn();
        @(negedge clk);
        step();
        step();

        // Reset state
        chk("rst_S", 32'(bus0.S), 32'h0);
        chk("rst_I", 32'(bus0.I), 32'h0);
        chk("rst_strb", 32'(bus0.O_strb), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_round_done", 32'(rd0), 32'h0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);

        // All destinations ready, continuous data: 4 per destination in order
        begin_scn();
        for (int s = 0; s < 8; s++) push0(s, 4);
        rst0 = 1'b0; en = 1'b1; dst_ready = 8'hFF; in_valid = 1'b1;
        for (int g = 0; g < 80 && q0.size() != 0; g++) step();
        chk("s1_drain", 32'(q0.size()), 32'h0);
        chk("s1_first_cycle", 32'(first0), 32'd3);
        chk("s1_last_cycle", 32'(last0), 32'd41);
        chk("s1_round_done_at_last", 32'(rd_at_last), 32'h1);
        chk("s1_busy", 32'(busy0), 32'h1);
        in_valid = 1'b0;
        repeat (3) step();
        chk("s1_round_done_count", 32'(rdc0), 32'd1);

        // Only destinations 2 and 5 ready: grants alternate
        reset0();
        begin_scn();
        push0(2, 4); push0(5, 4); push0(2, 4); push0(5, 4);
        en = 1'b1; dst_ready = 8'b0010_0100; in_valid = 1'b1;
        for (int g = 0; g < 80 && q0.size() != 0; g++) step();
        chk("s2_drain", 32'(q0.size()), 32'h0);
        in_valid = 1'b0;
        repeat (2) step();
        chk("s2_total", 32'(tot0), 32'd16);
        chk("s2_round_done_count", 32'(rdc0), 32'd0);

        // Destination 3 drops out after two items
        reset0();
        begin_scn();
        push0(0, 4); push0(1, 4); push0(2, 4); push0(3, 2); push0(4, 4);
        en = 1'b1; dst_ready = 8'hFF; in_valid = 1'b1;
        for (int g = 0; g < 80 && q0.size() != 0; g++) begin
            step();
            if (scnt0[3] == 2) dst_ready[3] = 1'b0;
        end
        chk("s3_drain", 32'(q0.size()), 32'h0);
        chk("s3_bit3_count", 32'(scnt0[3]), 32'd2);

        // en dropped mid-burst at S=6, then re-enabled
        reset0();
        begin_scn();
        for (int s = 0; s < 6; s++) push0(s, 4);
        push0(6, 1); push0(6, 4);
        en = 1'b1; dst_ready = 8'hFF; in_valid = 1'b1; dropped = 0;
        for (int g = 0; g < 100 && q0.size() != 0; g++) begin
            step();
            if (dropped == 0 && scnt0[6] == 1) begin
                dropped = 1;
                en = 1'b0;
                #1;
                chk("s4_in_ready_en0", 32'(bus0.in_ready), 32'h0);
                step();
                chk("s4_busy_idle", 32'(busy0), 32'h0);
                chk("s4_strb_idle", 32'(bus0.O_strb), 32'h0);
                step();
                step();
                chk("s4_no_xfer_idle", 32'(tot0), 32'd25);
                en = 1'b1;
            end
        end
        chk("s4_drain", 32'(q0.size()), 32'h0);
        chk("s4_bit6_count", 32'(scnt0[6]), 32'd5);

        // Reset while routing to destination 4
        reset0();
        begin_scn();
        for (int s = 0; s < 4; s++) push0(s, 4);
        push0(4, 1);
        en = 1'b1; dst_ready = 8'hFF; in_valid = 1'b1;
        for (int g = 0; g < 80 && q0.size() != 0; g++) step();
        chk("s5_drain", 32'(q0.size()), 32'h0);
        chk("s5_strb_before_rst", 32'(bus0.O_strb), 32'h10);
        rst0 = 1'b1;
        step();
        chk("s5_strb_after_rst", 32'(bus0.O_strb), 32'h0);
        chk("s5_S_after_rst", 32'(bus0.S), 32'h0);
        chk("s5_busy_after_rst", 32'(busy0), 32'h0);
        chk("s5_in_ready_after_rst", 32'(bus0.in_ready), 32'h0);

        // BURST=1 instance: bit k of the pattern lands on output k
        en = 1'b0; in_valid = 1'b0;
        step();
        act1 = 1;
        p6 = 8'b1011_0010;
        for (int k = 0; k < 8; k++) pat[k] = p6[7-k];
        begin_scn();
        for (int k = 0; k < 8; k++) q1.push_back('{s: 3'(k), d: pat[k]});
        rst1 = 1'b0; en = 1'b1; dst_ready = 8'hFF; in_valid = 1'b1;
        for (int g = 0; g < 60 && q1.size() != 0; g++) step();
        chk("s6_drain", 32'(q1.size()), 32'h0);
        in_valid = 1'b0;
        repeat (3) step();
        chk("s6_total", 32'(tot1), 32'd8);
        chk("s6_round_done_count", 32'(rdc1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux8_rr_scheduler.md
Name: demux8_rr_scheduler

Overview:
- Sequencer and arbiter for the 1-to-8 demux datapath.
- Takes a single valid/ready bit stream and shares it round-robin among 8 destinations, granting one destination a burst of up to BURST items before rotating.
- Drives the demux select S and data I directly, plus a one-hot strobe marking which output carries a valid item.

Parameters:
- BURST, 4: max items routed to one destination per grant; legal range 1..16.
- CW, 4: burst counter width; must satisfy 2^CW >= BURST.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scheduler enable; 0 forces IDLE.
- in_valid  in  1  upstream item valid.
- in_data  in  1  upstream item bit.
- in_ready  out  1  upstream handshake ready (combinational from state and dst_ready).
- dst_ready  in  8  per-destination ready; bit i belongs to demux output i.
- S  out  3  registered demux select.
- I  out  1  registered demux data input.
- O_strb  out  8  registered one-hot strobe; bit S is high for the cycle I is valid.
- busy  out  1  high in SEARCH or ROUTE.
- round_done  out  1  one-cycle pulse when the round-robin pointer wraps 7->0.

Behaviour:
- Reset: state=IDLE, ptr=0, cnt=0, S=0, I=0, O_strb=0, round_done=0, busy=0. in_ready is 0 because the state is IDLE.
- A transfer occurs when in_valid & in_ready are both high at a clock edge.
- Latency: a transfer at edge k makes I=in_data, S=sel, O_strb=onehot(sel) visible after edge k, held for exactly one cycle. O_strb returns to 0 on the next cycle with no transfer. S and I hold their last values when idle.
- IDLE:
  - in_ready=0.
  - en=1 -> SEARCH.
- SEARCH:
  - in_ready=0.
  - grant = first i in order ptr, ptr+1, ... ptr+7 (mod 8) with dst_ready[i]=1.
  - No ready bit set -> stay in SEARCH.
  - Grant found -> sel<=grant, cnt<=0, go to ROUTE. Arbitration costs 1 cycle.
  - en=0 -> IDLE; this takes priority over a grant.
- ROUTE:
  - in_ready = dst_ready[sel] & en.
  - On a transfer: cnt<=cnt+1.
  - If the transfer makes cnt reach BURST (cnt==BURST-1 before the edge): ptr<=(sel+1) mod 8, go to SEARCH.
  - dst_ready[sel]=0 with no transfer: burst abandoned, ptr<=(sel+1) mod 8, go to SEARCH. A partial burst still counts as a used turn.
  - en=0: go to IDLE; ptr is unchanged and no transfer happens that cycle.
- round_done pulses in the cycle after any ptr update 7->0. It never fires for a ptr update that leaves ptr unchanged.
- Fairness: a destination that stays ready is granted within 8 grants.
- ptr arithmetic is 3-bit wrap; no range checks are needed.
- rst asserted mid-burst: all state returns to reset values at the next edge and O_strb clears. An in-flight item is dropped; upstream sees in_ready=0.
- BURST=1: exactly one item per grant, pure per-item round-robin.

Decomposition:
- Shared package demux_sched_pkg:
  - NUM_DST=8, SEL_W=3.
  - state typedef {IDLE, SEARCH, ROUTE}.
  - onehot8(sel) function.
- Sub-module rr_pick8: combinational rotate-priority finder. Inputs req[7:0] and ptr[2:0]; outputs gnt_idx[2:0] and gnt_vld. Reusable by other 8-way arbiters.

Test Plan:
- Reset, then en=1, dst_ready=8'hFF, in_valid=1 continuous, BURST=4 -> 4 strobes each on S=0,1,...,7 in order. One idle SEARCH cycle between bursts. round_done pulses once after the S=7 burst.
- dst_ready=8'b0010_0100, continuous data -> grants alternate S=2,5,2,5. No strobe ever appears on other bits.
- During an S=3 burst, drop dst_ready[3] after 2 items -> only 2 strobes on bit 3. The next grant is the lowest ready index >=4 (cyclic).
- en dropped mid-burst at S=6, cnt=1 -> no transfer that cycle, IDLE, ptr stays 6. Re-enable -> grant S=6 again with a fresh 4-item burst.
- rst pulsed while in ROUTE with O_strb=8'h10 -> next cycle O_strb=0, S=0, busy=0, in_ready=0.
- BURST=1, data pattern 1,0,1,1,0,0,1,0, all ready -> I/O_strb deliver bit k on output k. Then a round_done pulse.
